// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: load/store funct3 codes, LSU state encoding and request decode helpers.
package lsu_ctrl_pkg;
    localparam logic [2:0] L_BYTE   = 3'b000;
    localparam logic [2:0] L_HALF   = 3'b001;
    localparam logic [2:0] L_WORD   = 3'b010;
    localparam logic [2:0] L_BYTE_U = 3'b100;
    localparam logic [2:0] L_HALF_U = 3'b101;
    localparam logic [2:0] S_BYTE   = 3'b000;
    localparam logic [2:0] S_HALF   = 3'b001;
    localparam logic [2:0] S_WORD   = 3'b010;

    typedef enum logic [1:0] {LSU_IDLE, LSU_ACCESS, LSU_RDWAIT, LSU_ERR} lsu_state_e;

    function automatic logic req_ok(logic we, logic [2:0] f3, logic [1:0] a);
        logic legal, aligned;
        legal   = we ? (f3 inside {S_BYTE, S_HALF, S_WORD})
                     : (f3 inside {L_BYTE, L_HALF, L_WORD, L_BYTE_U, L_HALF_U});
        aligned = (f3[1:0] == 2'b01) ? !a[0] : (f3[1:0] == 2'b10) ? (a == 2'b00) : 1'b1;
        return legal && aligned;
    endfunction

    function automatic logic [3:0] byte_mask(logic [2:0] f3, logic [1:0] a);
        return (f3 == S_BYTE) ? 4'b0001 << a : (f3 == S_HALF) ? 4'b0011 << a : 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_rep(logic [2:0] f3, logic [31:0] d);
        return (f3 == S_BYTE) ? {4{d[7:0]}} : (f3 == S_HALF) ? {2{d[15:0]}} : d;
    endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake between the execute stage and the LSU.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_err, resp_rdata);
    modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_err, resp_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword of a RAM word and extends it.
module lsu_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] ram_rdata,
    output logic [31:0] rdata
);
    logic [31:0] sh;
    assign sh = ram_rdata >> {addr, 3'b000};
    always_comb
        rdata = (funct3 == L_BYTE)   ? {{24{sh[7]}}, sh[7:0]}   :
                (funct3 == L_HALF)   ? {{16{sh[15]}}, sh[15:0]} :
                (funct3 == L_BYTE_U) ? {24'b0, sh[7:0]}         :
                (funct3 == L_HALF_U) ? {16'b0, sh[15:0]}        : ram_rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller driving a synchronous-read, byte-write-enabled data RAM.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    lsu_ctrl_if.slave         bus,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    lsu_state_e  state, state_n;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] ld_data;
    logic        accept, ok;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];
    assign accept = (state == LSU_IDLE) && bus.req_valid;
    assign ok = req_ok(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign bus.req_ready = (state == LSU_IDLE);

    lsu_load_align u_align (
        .funct3    (f3_q),
        .addr      (lo_q),
        .ram_rdata (ram_rdata),
        .rdata     (ld_data)
    );

    // ram_addr/ram_wdata only load for legal requests so they hold through ERR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LSU_IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b0;
            lo_q      <= 2'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                we_q <= bus.req_we;
                f3_q <= bus.req_funct3;
                lo_q <= bus.req_addr[1:0];
            end
            if (accept && ok) begin
                ram_addr  <= bus.req_addr[ADDR_W-1:2];
                ram_wdata <= wdata_rep(bus.req_funct3, bus.req_wdata);
            end
        end
    end

    always_comb begin
        state_n        = state;
        ram_en         = 1'b0;
        ram_we         = 4'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'b0;
        case (state)
            LSU_IDLE:   state_n = accept ? (ok ? LSU_ACCESS : LSU_ERR) : LSU_IDLE;
            LSU_ACCESS: begin
                ram_en         = !we_q;
                ram_we         = we_q ? byte_mask(f3_q, lo_q) : 4'b0;
                bus.resp_valid = we_q;
                state_n        = we_q ? LSU_IDLE : LSU_RDWAIT;
            end
            LSU_RDWAIT: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = ld_data;
                state_n        = LSU_IDLE;
            end
            LSU_ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
                state_n        = LSU_IDLE;
            end
            default:    state_n = LSU_IDLE;
        endcase
    end
endmodule
